// File: rtl/arm7tdmi_pkg.sv
// Shared types and op-decode helpers for the ARM7TDMI multiply sequencer.
package arm7tdmi_pkg;

   typedef enum logic [2:0] {
      MUL_OP_MUL   = 3'b000,
      MUL_OP_MLA   = 3'b001,
      MUL_OP_UMULL = 3'b100,
      MUL_OP_UMLAL = 3'b101,
      MUL_OP_SMULL = 3'b110,
      MUL_OP_SMLAL = 3'b111
   } mul_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   function automatic logic op_is_long(input logic [2:0] op);
      return op[2];
   endfunction

   // The signed bit only matters for long ops; short codes 01x alias 00x.
   function automatic logic op_is_signed(input logic [2:0] op);
      return op[2] & op[1];
   endfunction

   function automatic logic op_is_acc(input logic [2:0] op);
      return op[0];
   endfunction

endpackage

// File: rtl/arm7tdmi_mul_seq_if.sv
// Request/response bundle between the execute stage and the multiply sequencer.
// start_i is taken on any rising edge where busy_o=0 (no backpressure, no queueing);
// done_o is a single-cycle pulse and results/flags stay valid until the next finish.
interface arm7tdmi_mul_seq_if #(
   parameter int DATA_W = 32
);
   logic              start_i;
   logic [2:0]        op_i;
   logic [DATA_W-1:0] rm_i;
   logic [DATA_W-1:0] rs_i;
   logic [DATA_W-1:0] acc_lo_i;
   logic [DATA_W-1:0] acc_hi_i;
   logic              flush_i;
   logic              busy_o;
   logic              done_o;
   logic [DATA_W-1:0] result_lo_o;
   logic [DATA_W-1:0] result_hi_o;
   logic              flag_n_o;
   logic              flag_z_o;

   modport master (
      output start_i, op_i, rm_i, rs_i, acc_lo_i, acc_hi_i, flush_i,
      input  busy_o, done_o, result_lo_o, result_hi_o, flag_n_o, flag_z_o
   );

   modport slave (
      input  start_i, op_i, rm_i, rs_i, acc_lo_i, acc_hi_i, flush_i,
      output busy_o, done_o, result_lo_o, result_hi_o, flag_n_o, flag_z_o
   );
endinterface

// File: rtl/arm7tdmi_mul_pp.sv
// One multiplier iteration: shifted partial product, optional -mcand correction,
// next Rs remainder and the termination decision.
module arm7tdmi_mul_pp #(
   parameter int DATA_W         = 32,
   parameter int BITS_PER_CYCLE = 8,
   parameter int EARLY_TERM     = 1,
   parameter int K_W            = $clog2(DATA_W / BITS_PER_CYCLE + 1)
) (
   input  logic [2*DATA_W-1:0] i_mcand,
   input  logic [DATA_W-1:0]   i_rs_rem,
   input  logic [K_W-1:0]      i_k,
   input  logic                i_arith,
   output logic [2*DATA_W-1:0] o_addend,
   output logic [DATA_W-1:0]   o_rs_next,
   output logic [K_W-1:0]      o_k_next,
   output logic                o_finish
);
   localparam int B     = BITS_PER_CYCLE;
   localparam int W2    = 2 * DATA_W;
   localparam int ITERS = DATA_W / BITS_PER_CYCLE;
   localparam int SH_W  = $clog2(W2);

   logic [W2-1:0]            w_chunk_ext;
   logic [SH_W-1:0]          w_sh_pp;
   logic [SH_W-1:0]          w_sh_corr;
   logic [W2-1:0]            w_pp;
   logic [W2-1:0]            w_corr;
   logic signed [DATA_W-1:0] w_rs_s;
   logic signed [DATA_W-1:0] w_rs_asr;
   logic                     w_zero;
   logic                     w_ones;
   logic                     w_limit;

   assign w_chunk_ext = {{(W2-B){1'b0}}, i_rs_rem[B-1:0]};
   assign w_sh_pp     = SH_W'(i_k) * SH_W'(B);
   assign w_pp        = (i_mcand * w_chunk_ext) << w_sh_pp;

   assign w_rs_s      = i_rs_rem;
   assign w_rs_asr    = w_rs_s >>> B;
   assign o_rs_next   = i_arith ? w_rs_asr : (i_rs_rem >> B);
   assign o_k_next    = i_k + K_W'(1);

   assign w_zero      = (o_rs_next == '0);
   assign w_ones      = (&o_rs_next) & i_arith;
   assign w_limit     = (o_k_next == K_W'(ITERS));
   assign o_finish    = w_limit | ((EARLY_TERM != 0) & (w_zero | w_ones));

   // A remaining all-ones Rs stands for -1 at weight 2^(k_new*B).
   assign w_sh_corr   = SH_W'(o_k_next) * SH_W'(B);
   assign w_corr      = (-i_mcand) << w_sh_corr;
   assign o_addend    = w_pp + ((w_ones & o_finish) ? w_corr : '0);

endmodule

// File: rtl/arm7tdmi_mul_seq.sv
// Multi-cycle MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit with ARM7-style early termination.
// State is exported on o_dbg_state for observation.
module arm7tdmi_mul_seq
   import arm7tdmi_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int BITS_PER_CYCLE = 8,
   parameter int EARLY_TERM     = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   arm7tdmi_mul_seq_if.slave  io_mul,
   output mul_state_t         o_dbg_state
);
   localparam int B     = BITS_PER_CYCLE;
   localparam int W2    = 2 * DATA_W;
   localparam int ITERS = DATA_W / BITS_PER_CYCLE;
   localparam int K_W   = $clog2(ITERS + 1);

   if (!(B == 1 || B == 2 || B == 4 || B == 8 || B == 16 || B == 32) ||
       (DATA_W % B) != 0) begin : g_bad_param
      $error("arm7tdmi_mul_seq: illegal BITS_PER_CYCLE/DATA_W combination");
   end

   mul_state_t        r_state;
   mul_state_t        w_next_state;
   logic [W2-1:0]     r_acc;
   logic [W2-1:0]     r_mcand;
   logic [DATA_W-1:0] r_rs_rem;
   logic [K_W-1:0]    r_k;
   logic              r_long;
   logic              r_arith;
   logic [DATA_W-1:0] r_res_lo;
   logic [DATA_W-1:0] r_res_hi;
   logic              r_n;
   logic              r_z;

   logic              w_start;
   logic              w_op_long;
   logic              w_op_sgn;
   logic              w_op_acc;
   logic [W2-1:0]     w_addend;
   logic [W2-1:0]     w_sum;
   logic [DATA_W-1:0] w_rs_next;
   logic [K_W-1:0]    w_k_next;
   logic              w_finish;

   assign w_start   = io_mul.start_i & (r_state != CALC);
   assign w_op_long = op_is_long(io_mul.op_i);
   assign w_op_sgn  = op_is_signed(io_mul.op_i);
   assign w_op_acc  = op_is_acc(io_mul.op_i);

   arm7tdmi_mul_pp #(
      .DATA_W         (DATA_W),
      .BITS_PER_CYCLE (BITS_PER_CYCLE),
      .EARLY_TERM     (EARLY_TERM),
      .K_W            (K_W)
   ) u_pp (
      .i_mcand   (r_mcand),
      .i_rs_rem  (r_rs_rem),
      .i_k       (r_k),
      .i_arith   (r_arith),
      .o_addend  (w_addend),
      .o_rs_next (w_rs_next),
      .o_k_next  (w_k_next),
      .o_finish  (w_finish)
   );

   assign w_sum = r_acc + w_addend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         CALC: begin
            if (io_mul.flush_i)  w_next_state = IDLE;
            else if (w_finish)   w_next_state = DONE;
         end
         default: w_next_state = w_start ? CALC : IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_rs_rem <= '0;
         r_k      <= '0;
         r_long   <= 1'b0;
         r_arith  <= 1'b0;
         r_res_lo <= '0;
         r_res_hi <= '0;
         r_n      <= 1'b0;
         r_z      <= 1'b0;
      end else if (w_start) begin
         r_mcand  <= w_op_sgn ? {{DATA_W{io_mul.rm_i[DATA_W-1]}}, io_mul.rm_i}
                              : {{DATA_W{1'b0}}, io_mul.rm_i};
         r_acc    <= !w_op_acc ? '0
                   : w_op_long ? {io_mul.acc_hi_i, io_mul.acc_lo_i}
                               : {{DATA_W{1'b0}}, io_mul.acc_lo_i};
         r_rs_rem <= io_mul.rs_i;
         r_k      <= '0;
         r_long   <= w_op_long;
         // Only unsigned long ops shift Rs logically.
         r_arith  <= ~w_op_long | w_op_sgn;
      end else if (r_state == CALC && !io_mul.flush_i) begin
         r_acc    <= w_sum;
         r_rs_rem <= w_rs_next;
         r_k      <= w_k_next;
         if (w_finish) begin
            r_res_lo <= w_sum[DATA_W-1:0];
            r_res_hi <= r_long ? w_sum[W2-1:DATA_W] : '0;
            r_n      <= r_long ? w_sum[W2-1] : w_sum[DATA_W-1];
            r_z      <= r_long ? (w_sum == '0) : (w_sum[DATA_W-1:0] == '0);
         end
      end
   end

   assign io_mul.busy_o      = (r_state == CALC);
   assign io_mul.done_o      = (r_state == DONE);
   assign io_mul.result_lo_o = r_res_lo;
   assign io_mul.result_hi_o = r_res_hi;
   assign io_mul.flag_n_o    = r_n;
   assign io_mul.flag_z_o    = r_z;
   assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_arm7tdmi_mul_seq.sv
// Bench for arm7tdmi_mul_seq: vector table, random ops against a 64-bit model,
// and hand sequences for ignored start, flush and mid-operation reset.
module tb_arm7tdmi_mul_seq;
   import arm7tdmi_pkg::*;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] rm;
      logic [31:0] rs;
      logic [31:0] al;
      logic [31:0] ah;
      logic [31:0] e_hi;
      logic [31:0] e_lo;
      logic        e_n;
      logic        e_z;
      int          e_it;
   } vec_t;

   logic clk;
   logic rst_n;
   mul_state_t dbg0;
   mul_state_t dbg1;

   arm7tdmi_mul_seq_if #(.DATA_W(32)) mif0 ();
   arm7tdmi_mul_seq_if #(.DATA_W(32)) mif1 ();

   arm7tdmi_mul_seq #(.DATA_W(32), .BITS_PER_CYCLE(8), .EARLY_TERM(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .io_mul(mif0), .o_dbg_state(dbg0));
   arm7tdmi_mul_seq #(.DATA_W(32), .BITS_PER_CYCLE(8), .EARLY_TERM(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .io_mul(mif1), .o_dbg_state(dbg1));

   logic [65:0] exp_q[$];
   int          iter_q[$];
   int          n_cmp;
   int          n_fail;
   vec_t        vecs[15];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [65:0] model(input logic [2:0] op, input logic [31:0] rm,
                                         input logic [31:0] rs, input logic [31:0] al,
                                         input logic [31:0] ah);
      logic [63:0] a, b, acc, r;
      logic        lng, sgn;
      lng = op[2];
      sgn = op[2] & op[1];
      a   = sgn ? {{32{rm[31]}}, rm} : {32'b0, rm};
      b   = sgn ? {{32{rs[31]}}, rs} : {32'b0, rs};
      acc = !op[0] ? 64'd0 : (lng ? {ah, al} : {32'b0, al});
      r   = a * b + acc;
      if (!lng) r[63:32] = 32'b0;
      return {r, (lng ? r[63] : r[31]), (r == 64'd0)};
   endfunction

   function automatic int model_iters(input logic [2:0] op, input logic [31:0] rs);
      logic        arith;
      logic [31:0] r;
      arith = !op[2] | op[1];
      r     = rs;
      for (int k = 1; k <= 4; k++) begin
         r = arith ? 32'($signed(r) >>> 8) : (r >> 8);
         if (k == 4) return 4;
         if (r == 32'd0 || (arith && (&r))) return k;
      end
      return 4;
   endfunction

   // Pops one expectation per done pulse and checks the busy-cycle count before it.
   task automatic monitor_loop();
      int          busy_cnt;
      logic [65:0] e;
      int          it;
      busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) busy_cnt = 0;
         else if (mif0.done_o) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 128'(mif0.done_o), 128'(0));
            end else begin
               e  = exp_q.pop_front();
               it = iter_q.pop_front();
               chk("result", {mif0.result_hi_o, mif0.result_lo_o, mif0.flag_n_o, mif0.flag_z_o}, 128'(e));
               chk("iterations", 128'(busy_cnt), 128'(it));
            end
            busy_cnt = 0;
         end else if (mif0.busy_o) busy_cnt++;
         else busy_cnt = 0;
      end
   endtask

   task automatic drive0(input logic [2:0] op, input logic [31:0] rm, input logic [31:0] rs,
                         input logic [31:0] al, input logic [31:0] ah);
      mif0.op_i = op; mif0.rm_i = rm; mif0.rs_i = rs;
      mif0.acc_lo_i = al; mif0.acc_hi_i = ah;
   endtask

   task automatic wait_done0(input string name);
      int n;
      n = 0;
      while (!mif0.done_o && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!mif0.done_o) chk(name, 128'(0), 128'(1));
   endtask

   // Returns on the negedge of the DONE cycle, so a follow-up call with
   // wait_idle=0 issues a back-to-back start.
   task automatic run_op(input vec_t v, input bit wait_idle);
      if (wait_idle) @(negedge clk);
      exp_q.push_back({v.e_hi, v.e_lo, v.e_n, v.e_z});
      iter_q.push_back(v.e_it);
      drive0(v.op, v.rm, v.rs, v.al, v.ah);
      mif0.start_i = 1'b1;
      @(negedge clk);
      mif0.start_i = 1'b0;
      wait_done0("done_timeout");
   endtask

   initial begin
      vec_t        v;
      logic [65:0] m;
      int          n, dones;

      n_cmp = 0;
      n_fail = 0;
      rst_n = 1'b0;
      mif0.start_i = 1'b0; mif0.flush_i = 1'b0; drive0(3'b000, 0, 0, 0, 0);
      mif1.start_i = 1'b0; mif1.flush_i = 1'b0;
      mif1.op_i = 3'b000; mif1.rm_i = 0; mif1.rs_i = 0; mif1.acc_lo_i = 0; mif1.acc_hi_i = 0;

      //           op      rm            rs            acc_lo        acc_hi        exp_hi        exp_lo        n  z  iters
      vecs[0]  = '{3'b000, 32'd3,        32'd5,        32'd0,        32'd0,        32'h0,        32'd15,       0, 0, 1};
      vecs[1]  = '{3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd0,        32'hFFFFFFFE, 32'h00000001, 1, 0, 4};
      vecs[2]  = '{3'b110, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0,        32'd0,        32'h0,        32'd6,        0, 0, 1};
      vecs[3]  = '{3'b101, 32'd1,        32'd1,        32'hFFFFFFFF, 32'd1,        32'd2,        32'd0,        0, 0, 1};
      vecs[4]  = '{3'b001, 32'd0,        32'd0,        32'd0,        32'd0,        32'h0,        32'd0,        0, 1, 1};
      vecs[5]  = '{3'b000, 32'd7,        32'hFFFFFFFF, 32'd0,        32'd0,        32'h0,        32'hFFFFFFF9, 1, 0, 1};
      vecs[6]  = '{3'b111, 32'h00010000, 32'hFFFF0000, 32'd5,        32'd0,        32'hFFFFFFFF, 32'h00000005, 1, 0, 2};
      vecs[7]  = '{3'b100, 32'h12345678, 32'h00000100, 32'd0,        32'd0,        32'h00000012, 32'h34567800, 0, 0, 2};
      vecs[8]  = '{3'b001, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        32'h0,        32'd1,        0, 0, 3};
      vecs[9]  = '{3'b110, 32'h80000000, 32'h80000000, 32'd0,        32'd0,        32'h40000000, 32'h0,        0, 0, 4};
      vecs[10] = '{3'b101, 32'd0,        32'd0,        32'd0,        32'h80000000, 32'h80000000, 32'h0,        1, 0, 1};
      vecs[11] = '{3'b111, 32'd1,        32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 1, 1};
      vecs[12] = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'd0,        32'd0,        32'h0,        32'hFFFFFFFE, 1, 0, 1};
      vecs[13] = '{3'b100, 32'd3,        32'h80000000, 32'd0,        32'd0,        32'd1,        32'h80000000, 0, 0, 4};
      vecs[14] = '{3'b011, 32'd2,        32'd3,        32'd10,       32'd0,        32'h0,        32'd16,       0, 0, 1};

      fork
         monitor_loop();
      join_none

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy",  128'(mif0.busy_o),      128'(0));
      chk("rst_done",  128'(mif0.done_o),      128'(0));
      chk("rst_lo",    128'(mif0.result_lo_o), 128'(0));
      chk("rst_hi",    128'(mif0.result_hi_o), 128'(0));
      chk("rst_flags", 128'({mif0.flag_n_o, mif0.flag_z_o}), 128'(0));
      chk("rst_state", 128'(dbg0), 128'(IDLE));
      rst_n = 1'b1;
      @(negedge clk);

      // Vector table, issued back-to-back
      for (int i = 0; i < 15; i++) run_op(vecs[i], (i == 0));

      // Random ops against the reference model, with idle gaps
      for (int i = 0; i < 24; i++) begin
         v.op = 3'($urandom_range(0, 7));
         v.rm = $urandom();
         case ($urandom_range(0, 2))
            0:       v.rs = $urandom();
            1:       v.rs = 32'($urandom_range(0, 300));
            default: v.rs = -32'($urandom_range(1, 300));
         endcase
         v.al = $urandom();
         v.ah = $urandom();
         m = model(v.op, v.rm, v.rs, v.al, v.ah);
         {v.e_hi, v.e_lo, v.e_n, v.e_z} = m;
         v.e_it = model_iters(v.op, v.rs);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_op(v, 1'b1);
      end

      // MLA 0*0 without early termination runs all four iterations
      @(negedge clk);
      mif1.op_i = 3'b001; mif1.rm_i = 0; mif1.rs_i = 0; mif1.acc_lo_i = 0; mif1.acc_hi_i = 0;
      mif1.start_i = 1'b1;
      @(negedge clk);
      mif1.start_i = 1'b0;
      n = 0;
      while (!mif1.done_o && n < 40) begin
         if (mif1.busy_o) n++;
         @(negedge clk);
      end
      chk("noet_iterations", 128'(n), 128'(4));
      chk("noet_result", {mif1.result_hi_o, mif1.result_lo_o, mif1.flag_n_o, mif1.flag_z_o}, 128'(1));

      // Second start in cycle 2 is ignored
      @(negedge clk);
      exp_q.push_back({32'd1, 32'h80000000, 1'b0, 1'b0});
      iter_q.push_back(4);
      drive0(3'b100, 32'd3, 32'h80000000, 0, 0);
      mif0.start_i = 1'b1;
      @(negedge clk);
      mif0.start_i = 1'b0;
      @(negedge clk);
      drive0(3'b000, 32'd9, 32'd9, 0, 0);
      mif0.start_i = 1'b1;
      @(negedge clk);
      mif0.start_i = 1'b0;
      wait_done0("ign_done_timeout");
      @(negedge clk);
      chk("ign_not_queued", 128'(mif0.busy_o), 128'(0));

      // Flush in cycle 3: idle in cycle 4, no done, results held
      drive0(3'b100, 32'd5, 32'h80000000, 0, 0);
      mif0.start_i = 1'b1;
      @(negedge clk);
      mif0.start_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      mif0.flush_i = 1'b1;
      @(negedge clk);
      mif0.flush_i = 1'b0;
      chk("flush_busy", 128'(mif0.busy_o), 128'(0));
      chk("flush_state", 128'(dbg0), 128'(IDLE));
      dones = 0;
      repeat (6) begin
         if (mif0.done_o) dones++;
         @(negedge clk);
      end
      chk("flush_no_done", 128'(dones), 128'(0));
      chk("flush_hold", {mif0.result_hi_o, mif0.result_lo_o, mif0.flag_n_o, mif0.flag_z_o},
          128'({32'd1, 32'h80000000, 1'b0, 1'b0}));

      // Reset in the middle of CALC
      drive0(3'b100, 32'd5, 32'h80000000, 0, 0);
      mif0.start_i = 1'b1;
      @(negedge clk);
      mif0.start_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy",  128'(mif0.busy_o), 128'(0));
      chk("mid_rst_done",  128'(mif0.done_o), 128'(0));
      chk("mid_rst_res",   128'({mif0.result_hi_o, mif0.result_lo_o}), 128'(0));
      chk("mid_rst_flags", 128'({mif0.flag_n_o, mif0.flag_z_o}), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (6) begin
         @(negedge clk);
         if (mif0.done_o) dones++;
      end
      chk("mid_rst_no_done", 128'(dones), 128'(0));

      // Unit works again after reset
      run_op(vecs[13], 1'b1);
      repeat (3) @(negedge clk);
      chk("queue_empty", 128'(exp_q.size()), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
